fib_sequencer: RTL

- Controller and sequencer for the Fibonacci datapath.
- Accepts a command for N terms on a valid/ready handshake.
- Owns the two term registers and the adder, and streams F(0), F(1), F(2), … on a valid/ready output with backpressure.
- Terminates on count reached, abort, or unsigned overflow of the term width. Sits between the test/host command source and the result sink; runs on the single system clock.

---
 rtl/fib_sequencer_if.sv | 32 +++
 rtl/fib_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/fib_sequencer_if.sv
// fib_sequencer_if: command/stream bundle for fib_sequencer
// Signals: cmd_valid/cmd_ready/cmd_count (command), abort, out_valid/out_ready/out_term/out_index (term stream),
//   done (end pulse), overflow (sticky end-by-overflow), busy; stall_cycles only with FIB_STALL_CNT_EN.
// Modports: master = command source and result sink, slave = the sequencer.
interface fib_sequencer_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_term;
  logic [CNT_W-1:0] out_index;
  logic             done;
  logic             overflow;
  logic             busy;
`ifdef FIB_STALL_CNT_EN
  logic [31:0]      stall_cycles;
  modport master (output cmd_valid, cmd_count, abort, out_ready,
                  input cmd_ready, out_valid, out_term, out_index, done, overflow, busy, stall_cycles);
  modport slave  (input cmd_valid, cmd_count, abort, out_ready,
                  output cmd_ready, out_valid, out_term, out_index, done, overflow, busy, stall_cycles);
`else
  modport master (output cmd_valid, cmd_count, abort, out_ready,
                  input cmd_ready, out_valid, out_term, out_index, done, overflow, busy);
  modport slave  (input cmd_valid, cmd_count, abort, out_ready,
                  output cmd_ready, out_valid, out_term, out_index, done, overflow, busy);
`endif
endinterface

// File: rtl/fib_sequencer.sv
// fib_sequencer: accepts a term count and streams F(0), F(1), ... with backpressure
// Ports: clock (rising edge), reset_n (synchronous, active low),
//   bus (fib_sequencer_if.slave): cmd_valid/cmd_ready/cmd_count, abort,
//   out_valid/out_ready/out_term/out_index, done, overflow, busy.
// Optional macro FIB_STALL_CNT_EN adds bus.stall_cycles, a saturating count of stalled RUN cycles.
module fib_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input logic           clock,
  input logic           reset_n,
  fib_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             b_ovf_q;
  logic [CNT_W-1:0] idx_q, rem_q;
  logic             out_valid_q, done_q, overflow_q, busy_q, cmd_ready_q;
  logic [WIDTH:0]   sum;
  logic             last, stop;
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign last = rem_q == CNT_W'(1);
  // abort alone ends the run; an accept ends it on the final count or when the next term would not fit
  assign stop = bus.abort || (bus.out_ready && (last || b_ovf_q));
  always_ff @(posedge clock)
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= WIDTH'(1);
      b_ovf_q     <= 1'b0;
      idx_q       <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else case (state_q)
      IDLE: if (bus.cmd_valid) begin
        a_q         <= '0;
        b_q         <= WIDTH'(1);
        b_ovf_q     <= 1'b0;
        idx_q       <= '0;
        rem_q       <= bus.cmd_count;
        overflow_q  <= 1'b0;
        cmd_ready_q <= 1'b0;
        busy_q      <= 1'b1;
        state_q     <= (bus.cmd_count == '0) ? DONE : RUN;
        out_valid_q <= bus.cmd_count != '0;
        done_q      <= bus.cmd_count == '0;
      end
      RUN: begin
        if (bus.out_ready) begin
          a_q        <= b_q;
          b_q        <= sum[WIDTH-1:0];
          // the carry-out marks b as unrepresentable; the mark rides along until it reaches a
          b_ovf_q    <= b_ovf_q | sum[WIDTH];
          idx_q      <= idx_q + CNT_W'(1);
          rem_q      <= rem_q - CNT_W'(1);
          overflow_q <= !last && b_ovf_q;
        end
        if (stop) begin
          state_q     <= DONE;
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
        end
      end
      default: begin
        state_q     <= IDLE;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
        cmd_ready_q <= 1'b1;
      end
    endcase
  assign bus.cmd_ready = cmd_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_term  = a_q;
  assign bus.out_index = idx_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
`ifdef FIB_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clock)
    if (!reset_n || (state_q == IDLE && bus.cmd_valid)) stall_q <= '0;
    else if (state_q == RUN && !bus.out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  assign bus.stall_cycles = stall_q;
`endif
endmodule
